// File: rtl/operand_feeder.sv
// Operand feeder: queues operand pairs in a small FIFO, drives each pair to a combinational
// block for HOLD cycles, then captures the block's result with a one-cycle valid strobe.
module operand_feeder #(
   parameter int unsigned W     = 3,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned HOLD  = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [W-1:0]           in_a,
   input  logic [W-1:0]           in_b,
   output logic [W-1:0]           a_out,
   output logic [W-1:0]           b_out,
   input  logic [W-1:0]           c_in,
   output logic [W-1:0]           res_c,
   output logic                   res_valid,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;

   typedef enum logic [1:0] {StIdle, StDrive, StCapture} state_e;

   state_e         state_q, state_d;
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  count_q, count_d;
   logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
   logic [W-1:0]   a_q, b_q, res_c_q;
   logic           res_valid_q;
   logic [2*W-1:0] mem_q [DEPTH];
   logic           push, pop;

   // Ready looks only at registered occupancy, so a same-cycle pop never frees a full slot.
   assign in_ready = (count_q != CW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = (state_q == StIdle) && (count_q != '0);

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (pop) begin
               state_d    = StDrive;
               hold_cnt_d = HW'(HOLD - 1);
            end
         end
         StDrive: begin
            if (hold_cnt_q == '0) begin
               state_d = StCapture;
            end else begin
               hold_cnt_d = hold_cnt_q - HW'(1);
            end
         end
         StCapture: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         hold_cnt_q  <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_c_q     <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         count_q     <= count_d;
         res_valid_q <= (state_q == StCapture);
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q   <= rd_ptr_q + AW'(1);
            {a_q, b_q} <= mem_q[rd_ptr_q];
         end
         if (state_q == StCapture) begin
            res_c_q <= c_in;
         end
      end
   end

   // Storage needs no reset: the pointers and count alone define which entries are live.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= {in_a, in_b};
      end
   end

   assign a_out     = a_q;
   assign b_out     = b_q;
   assign res_c     = res_c_q;
   assign res_valid = res_valid_q;
   assign busy      = (state_q != StIdle);
   assign count     = count_q;

endmodule

// File: tb/tb_operand_feeder.sv
// Directed bench for operand_feeder; the attached code1 stand-in computes c = a - b, or the
// low bits of the cycle index when cycle-accurate capture timing is being checked.
module tb_operand_feeder;

   localparam int unsigned W     = 3;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned HOLD  = 10;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   in_valid;
   logic                   in_ready;
   logic [W-1:0]           in_a;
   logic [W-1:0]           in_b;
   logic [W-1:0]           a_out;
   logic [W-1:0]           b_out;
   logic [W-1:0]           c_in;
   logic [W-1:0]           res_c;
   logic                   res_valid;
   logic                   busy;
   logic [$clog2(DEPTH):0] count;

   int             checks    = 0;
   int             failures  = 0;
   int             rel       = 0;
   int             max_count = 0;
   logic           cyc_mode  = 1'b0;
   logic [2*W-1:0] send_q[$];
   logic [W-1:0]   got_q[$];
   int             pulse_q[$];
   int             exp_q[$];

   operand_feeder #(
      .W     (W),
      .DEPTH (DEPTH),
      .HOLD  (HOLD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .a_out     (a_out),
      .b_out     (b_out),
      .c_in      (c_in),
      .res_c     (res_c),
      .res_valid (res_valid),
      .busy      (busy),
      .count     (count)
   );

   always #5 clk = ~clk;

   assign c_in = cyc_mode ? W'(rel) : W'(a_out - b_out);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      rel++;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic start_test();
      rel       = 0;
      max_count = 0;
      got_q.delete();
      pulse_q.delete();
      exp_q.delete();
   endtask

   // Offers queued pairs in order, logs every result pulse and tracks peak occupancy.
   task automatic run(input int n);
      logic pushed;
      for (int i = 0; i < n; i++) begin
         if (send_q.size() > 0) begin
            in_valid = 1'b1;
            in_a     = send_q[0][2*W-1:W];
            in_b     = send_q[0][W-1:0];
         end else begin
            in_valid = 1'b0;
         end
         pushed = in_valid && in_ready;
         next_cycle();
         if (pushed) void'(send_q.pop_front());
         if (res_valid) begin
            got_q.push_back(res_c);
            pulse_q.push_back(rel);
         end
         if (int'(count) > max_count) max_count = int'(count);
      end
      in_valid = 1'b0;
   endtask

   task automatic check_results(input string tag, input int exp_max);
      check({tag, "_npulses"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         check($sformatf("%s_res%0d", tag, i), (i < got_q.size()) ? 32'(got_q[i]) : 'x,
               exp_q[i]);
         if (i == 0) begin
            check({tag, "_first_pulse"}, (pulse_q.size() > 0) ? pulse_q[0] : -1, 13);
         end else begin
            check($sformatf("%s_gap%0d", tag, i),
                  (i < pulse_q.size()) ? pulse_q[i] - pulse_q[i-1] : -1, HOLD + 2);
         end
      end
      check({tag, "_max_count"}, max_count, exp_max);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;

      // Reset state, then a single pair with c_in tracking the cycle index.
      do_reset();
      check("rst_in_ready", in_ready, 1);
      check("rst_count", count, 0);
      check("rst_busy", busy, 0);
      check("rst_a_out", a_out, 0);
      check("rst_b_out", b_out, 0);
      check("rst_res_c", res_c, 0);
      check("rst_res_valid", res_valid, 0);
      start_test();
      cyc_mode = 1'b1;
      send_q.push_back({3'd1, 3'd0});
      exp_q.push_back(4);
      run(1);
      check("single_c1_count", count, 1);
      check("single_c1_busy", busy, 0);
      check("single_c1_a", a_out, 0);
      run(1);
      check("single_c2_a", a_out, 1);
      check("single_c2_b", b_out, 0);
      check("single_c2_busy", busy, 1);
      check("single_c2_count", count, 0);
      run(9);
      check("single_c11_a", a_out, 1);
      check("single_c11_busy", busy, 1);
      run(1);
      check("single_c12_valid", res_valid, 0);
      check("single_c12_busy", busy, 1);
      run(1);
      check("single_c13_valid", res_valid, 1);
      check("single_c13_res", res_c, 4);
      check("single_c13_busy", busy, 0);
      run(1);
      check("single_c14_valid", res_valid, 0);
      check("single_c14_a_hold", a_out, 1);
      check("single_c14_b_hold", b_out, 0);
      cyc_mode = 1'b0;
      check_results("single", 1);

      // Three pairs back to back.
      do_reset();
      start_test();
      send_q.push_back({3'd1, 3'd0});
      send_q.push_back({3'd1, 3'd4});
      send_q.push_back({3'd5, 3'd1});
      exp_q = '{1, 5, 4};
      run(40);
      check_results("three", 2);

      // Fill while the FSM is busy with an earlier pair; the last offer must stall.
      do_reset();
      start_test();
      send_q.push_back({3'd1, 3'd0});
      run(2);
      send_q.push_back({3'd3, 3'd1});
      send_q.push_back({3'd6, 3'd3});
      send_q.push_back({3'd0, 3'd4});
      send_q.push_back({3'd7, 3'd2});
      send_q.push_back({3'd2, 3'd4});
      run(4);
      check("fill_c6_count", count, 4);
      check("fill_c6_ready", in_ready, 0);
      run(7);
      check("fill_c13_ready", in_ready, 0);
      check("fill_c13_busy", busy, 0);
      run(1);
      check("fill_c14_ready", in_ready, 1);
      check("fill_c14_count", count, 3);
      run(1);
      check("fill_c15_count", count, 4);
      check("fill_c15_pending", send_q.size(), 0);
      run(70);
      exp_q = '{1, 2, 3, 4, 5, 6};
      check_results("fill", 4);

      // Nine pairs streamed continuously; pointers wrap twice.
      do_reset();
      start_test();
      for (int i = 0; i < 9; i++) begin
         send_q.push_back({W'(i + 1), W'(2 * i)});
      end
      exp_q = '{1, 0, 7, 6, 5, 4, 3, 2, 1};
      run(125);
      check_results("wrap", 4);

      // Push coinciding with a pop at count 2.
      do_reset();
      start_test();
      send_q.push_back({3'd4, 3'd1});
      send_q.push_back({3'd6, 3'd1});
      send_q.push_back({3'd3, 3'd5});
      run(13);
      check("simul_c13_count", count, 2);
      check("simul_c13_busy", busy, 0);
      send_q.push_back({3'd7, 3'd2});
      run(1);
      check("simul_c14_count", count, 2);
      check("simul_c14_a", a_out, 6);
      check("simul_c14_b", b_out, 1);
      check("simul_c14_pending", send_q.size(), 0);
      run(50);
      exp_q = '{3, 5, 6, 5};
      check_results("simul", 2);

      // Reset in the sixth DRIVE cycle with two pairs queued and a push offered.
      start_test();
      send_q.push_back({3'd5, 3'd2});
      send_q.push_back({3'd1, 3'd1});
      send_q.push_back({3'd3, 3'd0});
      run(7);
      check("rstmid_pre_busy", busy, 1);
      check("rstmid_pre_count", count, 2);
      check("rstmid_pre_a", a_out, 5);
      check("rstmid_pre_res", res_c, 5);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_a     = 3'd7;
      in_b     = 3'd6;
      next_cycle();
      rst      = 1'b0;
      in_valid = 1'b0;
      check("rstmid_a", a_out, 0);
      check("rstmid_b", b_out, 0);
      check("rstmid_count", count, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_valid", res_valid, 0);
      check("rstmid_res", res_c, 0);
      check("rstmid_ready", in_ready, 1);
      max_count = 0;
      run(30);
      check("rstmid_no_pulse", got_q.size(), 0);
      check("rstmid_stays_empty", max_count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/operand_feeder.md
OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
REQ-001 Parameter W, default 3: operand and result width, matching the 3-bit a/b/c of code1.
REQ-002 Parameter DEPTH, default 4: operand FIFO depth in pairs; power of two, at least 2.
REQ-003 Parameter HOLD, default 10: number of cycles a pair is driven before c is sampled; at least 1.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  producer offers a pair.
REQ-007 in_ready  out  1  FIFO can accept; equals (count != DEPTH).
REQ-008 in_a, in_b  in  W  offered operand pair.
REQ-009 a_out, b_out  out  W  registered operands driven to code1 a/b.
REQ-010 c_in  in  W  code1 output c.
REQ-011 res_c  out  W  captured result.
REQ-012 res_valid  out  1  one-cycle strobe: res_c updated.
REQ-013 busy  out  1  high when the FSM is not IDLE.
REQ-014 count  out  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Function
REQ-015 A push SHALL occur on a cycle with in_valid && in_ready; the pair {in_a,in_b} SHALL be written at the write pointer.
REQ-016 FIFO order SHALL be strict first-in first-out; pointers SHALL wrap modulo DEPTH.
REQ-017 in_ready SHALL depend only on registered count; a push while full SHALL be impossible even if a pop occurs in the same cycle.
REQ-018 The FSM SHALL have states IDLE, DRIVE, and CAPTURE.
REQ-019 IDLE: if count != 0 (pre-push value), the FSM SHALL pop the head into a_out/b_out, load hold_cnt = HOLD-1, and go to DRIVE; otherwise it SHALL stay in IDLE.
REQ-020 DRIVE: a_out/b_out SHALL hold; if hold_cnt == 0 the FSM SHALL go to CAPTURE, else it SHALL decrement hold_cnt.
REQ-021 CAPTURE: the block SHALL register res_c <= c_in and set res_valid = 1 for exactly one cycle (the following cycle), then return to IDLE.
REQ-022 DRIVE SHALL last exactly HOLD cycles; per-pair period SHALL be HOLD+2 cycles (IDLE + DRIVE + CAPTURE); back-to-back pairs SHALL incur no extra gap.
REQ-023 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-024 A push into an empty FIFO during IDLE SHALL be popped on the next cycle, not the same cycle.
REQ-025 After the last pair is processed, a_out/b_out SHALL retain the last driven values.
REQ-026 count arithmetic SHALL never underflow or overflow; a pop SHALL only occur when count != 0.

Reset
REQ-027 Under rst, FSM = IDLE, pointers = 0, count = 0, hold_cnt = 0, a_out = b_out = 0, res_c = 0, res_valid = 0, busy = 0; in_ready SHALL be 1 from the first cycle after reset.
REQ-028 Reset mid-DRIVE or mid-CAPTURE SHALL abort without a res_valid pulse and SHALL discard FIFO contents.
REQ-029 Pushes coincident with rst SHALL be ignored.

Verification
REQ-030 Single pair: push (a=001, b=000) at cycle 0 -> a_out/b_out = 001/000 from cycle 2 for 10 cycles; res_valid at cycle 13 with res_c = c_in sampled at cycle 12.
REQ-031 Three pairs (001/000, 001/100, 101/001) pushed back-to-back -> the three res_valid pulses SHALL be spaced 12 cycles apart, with operands in order.
REQ-032 Fill: push 5 pairs with in_valid held high and FSM stalled by HOLD -> the 5th push SHALL wait until in_ready returns after a pop; count SHALL never exceed 4.
REQ-033 Wrap: push/pop 9 pairs continuously -> pointers SHALL wrap twice, ordering SHALL be preserved, and count SHALL stay at or below 4.
REQ-034 Reset at cycle 6 of DRIVE with 2 pairs queued -> all outputs SHALL be 0 next cycle, no res_valid pulse, count = 0.
REQ-035 Simultaneous push and pop with count = 2 -> count SHALL remain 2 and the popped pair SHALL be the oldest entry.
